// File: rtl/mac_pipe_unit.sv
// mac_pipe_unit: two-stage pipelined signed multiply-accumulate.
// Stage 1 registers the operand product and a valid flag. Stage 2 folds that
// product into the running accumulator. The accumulator either wraps or
// clamps at the signed limits, chosen by SATURATE. The active-low
// asynchronous reset clears both stages, so any product still in flight is
// dropped.
module mac_pipe_unit #(
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int               PROD_W  = 2 * DATA_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic             SAT_EN  = (SATURATE != 0);

  // Only the low ACC_W bits of the product can reach the accumulator.
  // The product is therefore reduced to ACC_W bits (sign-extended if ACC_W
  // is wider) before it is registered.
  logic [ACC_W-1:0] prod_s;
  logic [ACC_W-1:0] prod_r;
  logic             valid_r;
  logic [ACC_W-1:0] acc_next_s;
  logic [ACC_W-1:0] acc_r;

  // Two's-complement add with optional clamping. Overflow can only occur when
  // both addends have the same sign and the sum's sign differs from it.
  function automatic logic [ACC_W-1:0] add_clamp(
    input logic [ACC_W-1:0] x,
    input logic [ACC_W-1:0] y,
    input logic             sat_en
  );
    logic [ACC_W-1:0] sum;
    logic             ovf;
    sum = x + y;
    ovf = (x[ACC_W-1] == y[ACC_W-1]) && (sum[ACC_W-1] != x[ACC_W-1]);
    if (sat_en && ovf) begin
      if (x[ACC_W-1]) begin
        add_clamp = ACC_MIN;
      end else begin
        add_clamp = ACC_MAX;
      end
    end else begin
      add_clamp = sum;
    end
  endfunction

  // Full-width signed product of the operands, reduced to the accumulator width
  always_comb begin
    prod_s = ACC_W'($signed(PROD_W'(a)) * $signed(PROD_W'(b)));
  end

  // Stage 1: capture the product of an enabled pair; hold it otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_r  <= {ACC_W{1'b0}};
      valid_r <= 1'b0;
    end else if (enable) begin
      prod_r  <= prod_s;
      valid_r <= 1'b1;
    end else begin
      prod_r  <= prod_r;
      valid_r <= 1'b0;
    end
  end

  // Stage 2 next value: accumulate only when stage 1 holds a fresh product
  always_comb begin
    acc_next_s = acc_r;
    if (valid_r) begin
      acc_next_s = add_clamp(acc_r, prod_r, SAT_EN);
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Accumulator register; cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else begin
      acc_r <= acc_next_s;
    end
  end

  assign acc = acc_r;

endmodule

// File: tb/tb_mac_pipe_unit.sv
// Self-checking bench for mac_pipe_unit: a wrapping and a saturating instance
// share one stimulus stream and are compared against an arithmetic model.
module tb_mac_pipe_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] acc_wrap;
  logic [31:0] acc_sat;

  int errors = 0;
  int checks = 0;

  // Reference model: exact sums in 64-bit arithmetic, then wrapped or clamped
  longint m_wrap = 0;
  longint m_sat  = 0;
  longint pend_q[$];   // products sampled on the previous edge, not yet summed

  mac_pipe_unit #(.DATA_W(32), .ACC_W(32), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b), .acc(acc_wrap)
  );

  mac_pipe_unit #(.DATA_W(32), .ACC_W(32), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b), .acc(acc_sat)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint prod32(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return longint'(int'(p));   // low 32 bits, read as signed
  endfunction

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  task automatic model_clear();
    pend_q.delete();
    m_wrap = 0;
    m_sat  = 0;
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge
  task automatic step(input string tag, input logic en, input logic [31:0] xa,
                      input logic [31:0] xb);
    longint p;
    enable = en;
    a = xa;
    b = xb;
    @(posedge clk);
    if (rst) begin
      while (pend_q.size() > 0) begin
        p = pend_q.pop_front();
        m_wrap = longint'(int'(m_wrap + p));
        m_sat  = clamp32(m_sat + p);
      end
      if (en) pend_q.push_back(prod32(xa, xb));
    end else begin
      model_clear();
    end
    @(negedge clk);
    check_val({tag, "_wrap"}, sx(acc_wrap), m_wrap);
    check_val({tag, "_sat"}, sx(acc_sat), m_sat);
  endtask

  // Mid-cycle asynchronous reset, held across an edge with enable high
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_val({tag, "_async_wrap"}, sx(acc_wrap), 0);
    check_val({tag, "_async_sat"}, sx(acc_sat), 0);
    enable = 1'b1;
    a = 32'd5;
    b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_rstwins"}, sx(acc_wrap), 0);
    rst = 1'b1;
    enable = 1'b0;
  endtask

  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_val("reset_wrap", sx(acc_wrap), 0);
    check_val("reset_sat", sx(acc_sat), 0);
    rst = 1'b1;

    // 1: reset mid-stream, then accumulate again from zero
    step("t1", 1'b1, 32'd2, 32'd3);
    step("t1", 1'b1, 32'd4, 32'd5);
    step("t1", 1'b1, 32'd6, 32'd7);
    check_val("t1_pre", sx(acc_wrap), 26);
    async_reset("t1");
    step("t1p", 1'b1, 32'd10, 32'd10);
    step("t1p", 1'b0, 32'd0, 32'd0);
    check_val("t1_post", sx(acc_wrap), 100);
    step("t1p", 1'b0, 32'd0, 32'd0);

    // 2: 3x3 window 1..9 against kernel -1,-1,-1,0,0,0,1,1,1
    async_reset("t2");
    for (int i = 1; i <= 9; i++) begin
      step("t2", 1'b1, 32'(i), (i <= 3) ? 32'hFFFFFFFF : ((i <= 6) ? 32'd0 : 32'd1));
    end
    step("t2", 1'b0, 32'd0, 32'd0);
    check_val("t2_sum", sx(acc_wrap), 18);
    repeat (3) step("t2", 1'b0, 32'd0, 32'd0);

    // 3: single pair, then stable hold
    async_reset("t3");
    step("t3", 1'b1, 32'hFFFFFFF9, 32'd6);
    step("t3", 1'b0, 32'd0, 32'd0);
    check_val("t3_prod", sx(acc_wrap), -42);
    repeat (4) step("t3", 1'b0, $urandom, $urandom);
    check_val("t3_hold", sx(acc_sat), -42);

    // 4: alternating enable; operands changed while disabled
    async_reset("t4");
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step("t4", 1'b1, 32'd5, 32'd3);
      else            step("t4", 1'b0, $urandom, $urandom);
    end
    step("t4", 1'b0, 32'd0, 32'd0);
    check_val("t4_sum", sx(acc_wrap), 45);

    // 5: overflow, wrap vs clamp
    async_reset("t5");
    step("t5", 1'b1, 32'h7FFFFFFF, 32'd1);
    step("t5", 1'b1, 32'h7FFFFFFF, 32'd1);
    step("t5", 1'b0, 32'd0, 32'd0);
    check_val("t5_wrap_const", longint'(acc_wrap), longint'(32'hFFFFFFFE));
    check_val("t5_sat_const", longint'(acc_sat), longint'(32'h7FFFFFFF));

    // 6: product 2^32 truncates to zero
    async_reset("t6");
    step("t6", 1'b1, 32'h00010000, 32'h00010000);
    step("t6", 1'b0, 32'd0, 32'd0);
    check_val("t6_trunc", sx(acc_wrap), 0);

    // Randomized stream with occasional resets and overflow-prone operands
    async_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd");
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          ra = $urandom;
          rb = $urandom;
        end else begin
          ra = 32'($signed(16'($urandom)));
          rb = 32'($signed(8'($urandom)));
        end
        step("rnd", ($urandom_range(0, 3) != 0), ra, rb);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
